// File: rtl/counter_4b_sched.sv
// Two-requester scheduler for one shared 4-bit up/down/load counter.
// Round-robin IDLE arbitration, fixed-length RUN with optional ripple-carry abort, one-cycle DONE.
module counter_4b_sched #(
    parameter int STEP_W    = 4,
    parameter bit RCO_ABORT = 1'b1
) (
    input  logic              sched_clk,
    input  logic              sched_reset,
    input  logic [1:0]        req,
    input  logic [1:0]        req0_mode,
    input  logic [1:0]        req1_mode,
    input  logic [3:0]        req0_D,
    input  logic [3:0]        req1_D,
    input  logic [STEP_W-1:0] req0_steps,
    input  logic [STEP_W-1:0] req1_steps,
    input  logic              cnt_rco,
    output logic              cnt_enable,
    output logic [1:0]        cnt_mode,
    output logic [3:0]        cnt_D,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [1:0]        MODE_LOAD = 2'b11;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              cnt_enable_q, cnt_enable_d;
    logic [1:0]        cnt_mode_q, cnt_mode_d;
    logic [3:0]        cnt_D_q, cnt_D_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        done_q, done_d;
    logic              busy_q, busy_d;

    logic              win;
    logic              owner_req;
    logic              rco_exit;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        step_d       = step_q;
        cnt_enable_d = cnt_enable_q;
        cnt_mode_d   = cnt_mode_q;
        cnt_D_d      = cnt_D_q;
        gnt_d        = gnt_q;
        done_d       = 2'b00;
        busy_d       = busy_q;
        win          = 1'b0;

        // Latched mode lives in cnt_mode_q for the whole run, so it is the one to test for load.
        owner_req = owner_q ? req[1] : req[0];
        rco_exit  = RCO_ABORT && (cnt_mode_q != MODE_LOAD) && cnt_rco;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    win          = (req == 2'b11) ? ptr_q : req[1];
                    owner_d      = win;
                    step_d       = win ? req1_steps : req0_steps;
                    cnt_mode_d   = win ? req1_mode  : req0_mode;
                    cnt_D_d      = win ? req1_D     : req0_D;
                    cnt_enable_d = 1'b1;
                    gnt_d        = win ? 2'b10 : 2'b01;
                    busy_d       = 1'b1;
                    state_d      = S_RUN;
                end
            end

            S_RUN: begin
                // Withdrawal outranks both normal exits and leaves the pointer alone.
                if (!owner_req) begin
                    state_d      = S_IDLE;
                    step_d       = '0;
                    cnt_enable_d = 1'b0;
                    cnt_mode_d   = 2'b00;
                    cnt_D_d      = 4'h0;
                    gnt_d        = 2'b00;
                    busy_d       = 1'b0;
                end else if ((step_q == '0) || rco_exit) begin
                    state_d      = S_DONE;
                    cnt_enable_d = 1'b0;
                    done_d       = owner_q ? 2'b10 : 2'b01;
                end else begin
                    step_d = step_q - STEP_ONE;
                end
            end

            S_DONE: begin
                state_d      = S_IDLE;
                ptr_d        = ~owner_q;
                step_d       = '0;
                cnt_enable_d = 1'b0;
                cnt_mode_d   = 2'b00;
                cnt_D_d      = 4'h0;
                gnt_d        = 2'b00;
                busy_d       = 1'b0;
            end

            default: begin
                state_d      = S_IDLE;
                step_d       = '0;
                cnt_enable_d = 1'b0;
                cnt_mode_d   = 2'b00;
                cnt_D_d      = 4'h0;
                gnt_d        = 2'b00;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sched_clk) begin
        if (!sched_reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            step_q       <= '0;
            cnt_enable_q <= 1'b0;
            cnt_mode_q   <= 2'b00;
            cnt_D_q      <= 4'h0;
            gnt_q        <= 2'b00;
            done_q       <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            step_q       <= step_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_mode_q   <= cnt_mode_d;
            cnt_D_q      <= cnt_D_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign cnt_enable = cnt_enable_q;
    assign cnt_mode   = cnt_mode_q;
    assign cnt_D      = cnt_D_q;
    assign gnt        = gnt_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_counter_4b_sched.sv
// Directed bench for counter_4b_sched: expected output words are queued per cycle and
// compared one clock later against {busy, done, gnt, cnt_enable, cnt_mode, cnt_D}.
module tb_counter_4b_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] req0_mode, req1_mode;
    logic [3:0] req0_D, req1_D;
    logic [3:0] req0_steps, req1_steps;
    logic       cnt_rco;
    logic       cnt_enable;
    logic [1:0] cnt_mode;
    logic [3:0] cnt_D;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    localparam logic [11:0] ZERO = 12'h000;

    counter_4b_sched #(.STEP_W(4), .RCO_ABORT(1'b1)) dut (
        .sched_clk  (clk),
        .sched_reset(rst_n),
        .req        (req),
        .req0_mode  (req0_mode),
        .req1_mode  (req1_mode),
        .req0_D     (req0_D),
        .req1_D     (req1_D),
        .req0_steps (req0_steps),
        .req1_steps (req1_steps),
        .cnt_rco    (cnt_rco),
        .cnt_enable (cnt_enable),
        .cnt_mode   (cnt_mode),
        .cnt_D      (cnt_D),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ov(input logic b, input logic [1:0] dn, input logic [1:0] g,
                                       input logic en, input logic [1:0] m, input logic [3:0] d);
        return {b, dn, g, en, m, d};
    endfunction

    // Queue the expectation for the coming edge, advance one clock, then score it.
    task automatic cyc(input string tag, input logic [11:0] e);
        logic [11:0] obs;
        logic [11:0] ex;
        string       t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs = {busy, done, gnt, cnt_enable, cnt_mode, cnt_D};
        ex  = exp_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert (obs === ex) else begin
            errors++;
            $error("FAIL %s: observed=%03h expected=%03h", t, obs, ex);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; cnt_rco = 1'b0;
        req0_mode = 2'b00; req1_mode = 2'b00;
        req0_D = 4'h0; req1_D = 4'h0;
        req0_steps = 4'd0; req1_steps = 4'd0;

        // Basic run: req0 mode +1, four enabled cycles, done pulse, back to idle.
        cyc("reset0", ZERO);
        cyc("reset1", ZERO);
        rst_n = 1'b1; req = 2'b01; req0_mode = 2'b10; req0_steps = 4'd3;
        for (int i = 0; i < 4; i++) cyc($sformatf("t1_run%0d", i), ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h0));
        cyc("t1_done", ov(1, 2'b01, 2'b01, 0, 2'b10, 4'h0));
        req = 2'b00;
        cyc("t1_idle0", ZERO);
        cyc("t1_idle1", ZERO);

        // Both requesting from reset release: order req0, req1, req0.
        rst_n = 1'b0;
        cyc("t2_reset", ZERO);
        rst_n = 1'b1; req = 2'b11;
        req0_mode = 2'b10; req0_D = 4'h3; req0_steps = 4'd1;
        req1_mode = 2'b01; req1_D = 4'h5; req1_steps = 4'd1;
        cyc("t2_a_run0", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h3));
        cyc("t2_a_run1", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h3));
        cyc("t2_a_done", ov(1, 2'b01, 2'b01, 0, 2'b10, 4'h3));
        cyc("t2_a_idle", ZERO);
        cyc("t2_b_run0", ov(1, 2'b00, 2'b10, 1, 2'b01, 4'h5));
        cyc("t2_b_run1", ov(1, 2'b00, 2'b10, 1, 2'b01, 4'h5));
        cyc("t2_b_done", ov(1, 2'b10, 2'b10, 0, 2'b01, 4'h5));
        cyc("t2_b_idle", ZERO);
        cyc("t2_c_run0", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h3));
        req = 2'b00;
        cyc("t2_c_withdraw", ZERO);

        // Ripple-carry abort on the third run cycle of a long +3 run.
        rst_n = 1'b0;
        cyc("t3_reset", ZERO);
        rst_n = 1'b1; req = 2'b10; req1_mode = 2'b00; req1_D = 4'h0; req1_steps = 4'd15;
        for (int i = 0; i < 3; i++) cyc($sformatf("t3_run%0d", i), ov(1, 2'b00, 2'b10, 1, 2'b00, 4'h0));
        cnt_rco = 1'b1;
        cyc("t3_rco_done", ov(1, 2'b10, 2'b10, 0, 2'b00, 4'h0));
        cnt_rco = 1'b0; req = 2'b00;
        cyc("t3_idle", ZERO);

        // Load mode, steps=0, rco held high: one run cycle.
        rst_n = 1'b0;
        cyc("t4_reset", ZERO);
        rst_n = 1'b1; req = 2'b01; req0_mode = 2'b11; req0_D = 4'hA; req0_steps = 4'd0; cnt_rco = 1'b1;
        cyc("t4_run", ov(1, 2'b00, 2'b01, 1, 2'b11, 4'hA));
        cyc("t4_done", ov(1, 2'b01, 2'b01, 0, 2'b11, 4'hA));
        req = 2'b00;
        cyc("t4_idle", ZERO);

        // Load mode ignores rco for a 3-cycle run; mid-run input changes must not leak through.
        req = 2'b01; req0_D = 4'h5; req0_steps = 4'd2;
        cyc("t4b_run0", ov(1, 2'b00, 2'b01, 1, 2'b11, 4'h5));
        req0_mode = 2'b00; req0_D = 4'hF; req0_steps = 4'd9;
        req1_mode = 2'b10; req1_D = 4'hC; req1_steps = 4'd7;
        cyc("t4b_run1", ov(1, 2'b00, 2'b01, 1, 2'b11, 4'h5));
        cyc("t4b_run2", ov(1, 2'b00, 2'b01, 1, 2'b11, 4'h5));
        cyc("t4b_done", ov(1, 2'b01, 2'b01, 0, 2'b11, 4'h5));
        req = 2'b00; cnt_rco = 1'b0;
        cyc("t4b_idle", ZERO);

        // Withdrawal in the second run cycle: no done, pointer stays on req0.
        rst_n = 1'b0;
        cyc("t5_reset", ZERO);
        rst_n = 1'b1; req = 2'b01; req0_mode = 2'b10; req0_D = 4'h1; req0_steps = 4'd5;
        req1_mode = 2'b01; req1_D = 4'h9; req1_steps = 4'd2;
        cyc("t5_run0", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h1));
        cyc("t5_run1", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h1));
        req = 2'b10;
        cyc("t5_withdraw", ZERO);
        req = 2'b11;
        cyc("t5_tie_req0", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h1));

        // Reset mid-run after the pointer has moved to req1.
        rst_n = 1'b0; req = 2'b00;
        cyc("t6_reset", ZERO);
        rst_n = 1'b1; req = 2'b01; req0_mode = 2'b10; req0_D = 4'h2; req0_steps = 4'd0;
        req1_mode = 2'b01; req1_D = 4'h7; req1_steps = 4'd3;
        cyc("t6_a_run", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h2));
        cyc("t6_a_done", ov(1, 2'b01, 2'b01, 0, 2'b10, 4'h2));
        req = 2'b10;
        cyc("t6_a_idle", ZERO);
        cyc("t6_b_run0", ov(1, 2'b00, 2'b10, 1, 2'b01, 4'h7));
        cyc("t6_b_run1", ov(1, 2'b00, 2'b10, 1, 2'b01, 4'h7));
        rst_n = 1'b0; req = 2'b11;
        cyc("t6_rst_mid", ZERO);
        cyc("t6_rst_hold", ZERO);
        rst_n = 1'b1;
        cyc("t6_tie_req0", ov(1, 2'b00, 2'b01, 1, 2'b10, 4'h2));
        cyc("t6_tie_done", ov(1, 2'b01, 2'b01, 0, 2'b10, 4'h2));
        req = 2'b00;
        cyc("t6_idle", ZERO);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
